// File: rtl/game_tick_ctrl.sv
// game_tick_ctrl: game-flow FSM (idle/run/pause/over) with tick generation,
// sticky end flags, saturating score and a speed level.
// The tick source is either external i_phase toggles (MODE=0) or an internal
// divider whose period shrinks as the level rises (MODE=1).
// Optional: define GAME_TICK_DROP_CNT_EN to add o_dropped, a saturating count
// of tick requests that were not accepted while running.
module game_tick_ctrl #(
    parameter int unsigned MODE             = 0,
    parameter int unsigned BASE_PERIOD      = 1000000,
    parameter int unsigned STEP             = 50000,
    parameter int unsigned MIN_PERIOD       = 200000,
    parameter int unsigned LEVELS           = 8,
    parameter int unsigned APPLES_PER_LEVEL = 4,
    parameter int unsigned SCORE_W          = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_phase,
    input  logic                       i_start,
    input  logic                       i_pause,
    input  logic                       i_ready,
    input  logic                       i_tick_ack,
    input  logic                       i_failure,
    input  logic                       i_success,
    input  logic                       i_eat,
    output logic                       o_tick,
    output logic [2:0]                 o_state,
    output logic                       o_failure,
    output logic                       o_success,
    output logic [SCORE_W-1:0]         o_score,
    output logic [$clog2(LEVELS)-1:0]  o_level
`ifdef GAME_TICK_DROP_CNT_EN
    ,
    output logic [7:0]                 o_dropped
`endif
);

    localparam int unsigned LW   = $clog2(LEVELS);
    localparam int unsigned PMAX = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
    localparam int unsigned CW   = $clog2(PMAX + 1);
    localparam int unsigned EW   = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        PAUSE     = 3'd2,
        OVER_FAIL = 3'd3,
        OVER_WIN  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            phase_q;
    logic [CW-1:0]   cnt_q;
    logic [EW-1:0]   eat_cnt_q;
    logic [31:0]     reduction;
    logic [31:0]     period_full;
    logic [CW-1:0]   period_m1;
    logic            in_run, in_idle, restart, set_fail, set_win;
    logic            req, accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: failure beats success beats pause
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (i_start) state_d = RUN;
            RUN:       if (i_failure)      state_d = OVER_FAIL;
                       else if (i_success) state_d = OVER_WIN;
                       else if (i_pause)   state_d = PAUSE;
            PAUSE:     if (i_failure)      state_d = OVER_FAIL;
                       else if (i_success) state_d = OVER_WIN;
                       else if (i_pause)   state_d = RUN;
            OVER_FAIL: if (i_start) state_d = IDLE;
            OVER_WIN:  if (i_start) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output decode of the FSM into control strobes
    always_comb begin
        in_run   = (state_q == RUN);
        in_idle  = (state_q == IDLE);
        restart  = ((state_q == OVER_FAIL) || (state_q == OVER_WIN)) && i_start;
        set_fail = ((state_q == RUN) || (state_q == PAUSE)) && (state_d == OVER_FAIL);
        set_win  = ((state_q == RUN) || (state_q == PAUSE)) && (state_d == OVER_WIN);
    end

    assign o_state = state_q;

    // Level-dependent divider period, clamped without unsigned underflow
    always_comb begin
        reduction = 32'(o_level) * STEP;
        if ((reduction >= BASE_PERIOD) || ((BASE_PERIOD - reduction) < MIN_PERIOD))
            period_full = MIN_PERIOD;
        else
            period_full = BASE_PERIOD - reduction;
        period_m1 = CW'(period_full - 32'd1);
    end

    // Tick request from the selected source and its acceptance
    always_comb begin
        if (MODE == 0) req = in_run && (i_phase != phase_q);
        else           req = in_run && (cnt_q >= period_m1);
        accept = req && i_ready && !o_tick && !i_tick_ack;
    end

    // Phase follower: tracking in every state means entering RUN sees no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= 1'b0;
        else        phase_q <= i_phase;
    end

    // Divider: counts in RUN, frozen elsewhere, holds at period-1 until accepted.
    // A level rise can shrink the period below the count, so >= catches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt_q <= '0;
        else if (MODE == 0 || in_idle) cnt_q <= '0;
        else if (in_run) begin
            if (cnt_q >= period_m1) cnt_q <= accept ? '0 : period_m1;
            else                    cnt_q <= cnt_q + CW'(1);
        end
    end

    // Pending tick: ack has priority over a new acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          o_tick <= 1'b0;
        else if (restart)    o_tick <= 1'b0;
        else if (i_tick_ack) o_tick <= 1'b0;
        else if (accept)     o_tick <= 1'b1;
    end

    // Sticky end-of-game flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_failure <= 1'b0;
            o_success <= 1'b0;
        end else if (restart) begin
            o_failure <= 1'b0;
            o_success <= 1'b0;
        end else begin
            if (set_fail) o_failure <= 1'b1;
            if (set_win)  o_success <= 1'b1;
        end
    end

    // Saturating score, eat counter and speed level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_score   <= '0;
            o_level   <= '0;
            eat_cnt_q <= '0;
        end else if (restart) begin
            o_score   <= '0;
            o_level   <= '0;
            eat_cnt_q <= '0;
        end else if (!in_idle && i_eat) begin
            if (o_score != '1) o_score <= o_score + SCORE_W'(1);
            if (eat_cnt_q == EW'(APPLES_PER_LEVEL - 1)) begin
                eat_cnt_q <= '0;
                if (o_level != LW'(LEVELS - 1)) o_level <= o_level + LW'(1);
            end else begin
                eat_cnt_q <= eat_cnt_q + EW'(1);
            end
        end
    end

`ifdef GAME_TICK_DROP_CNT_EN
    // Saturating count of requests in RUN that were not accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   o_dropped <= '0;
        else if (restart)                             o_dropped <= '0;
        else if (req && !accept && (o_dropped != '1)) o_dropped <= o_dropped + 8'd1;
    end
`endif

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Bench for game_tick_ctrl: one MODE=0 instance (SCORE_W=2) and one MODE=1
// instance with a short divider. Expected values are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_game_tick_ctrl;

    logic clk;
    logic rst_n;

    logic a_phase, a_start, a_pause, a_ready, a_ack, a_fail, a_succ, a_eat;
    logic a_tick, a_failure, a_success;
    logic [2:0] a_state;
    logic [1:0] a_score;
    logic [2:0] a_level;

    logic b_phase, b_start, b_pause, b_ready, b_ack, b_fail, b_succ, b_eat;
    logic b_tick, b_failure, b_success;
    logic [2:0] b_state;
    logic [7:0] b_score;
    logic [2:0] b_level;

`ifdef GAME_TICK_DROP_CNT_EN
    logic [7:0] a_drop, b_drop;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    game_tick_ctrl #(.MODE(0), .SCORE_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_phase(a_phase), .i_start(a_start),
        .i_pause(a_pause), .i_ready(a_ready), .i_tick_ack(a_ack),
        .i_failure(a_fail), .i_success(a_succ), .i_eat(a_eat),
        .o_tick(a_tick), .o_state(a_state), .o_failure(a_failure),
        .o_success(a_success), .o_score(a_score), .o_level(a_level)
`ifdef GAME_TICK_DROP_CNT_EN
        , .o_dropped(a_drop)
`endif
    );

    game_tick_ctrl #(.MODE(1), .BASE_PERIOD(20), .STEP(4), .MIN_PERIOD(8),
                     .APPLES_PER_LEVEL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_phase(b_phase), .i_start(b_start),
        .i_pause(b_pause), .i_ready(b_ready), .i_tick_ack(b_ack),
        .i_failure(b_fail), .i_success(b_succ), .i_eat(b_eat),
        .o_tick(b_tick), .o_state(b_state), .o_failure(b_failure),
        .o_success(b_success), .o_score(b_score), .o_level(b_level)
`ifdef GAME_TICK_DROP_CNT_EN
        , .o_dropped(b_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic want(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty observed %0d", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s observed %0d expected %0d", t, obs, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic b_wait(output int n);
        n = 0;
        while (b_tick !== 1'b1 && n < 300) begin
            cyc();
            n++;
        end
    endtask

    // Ack the current tick (optionally with an eat) and count cycles to the next
    task automatic b_next(input logic eat, output int n);
        b_ack = 1'b1;
        b_eat = eat;
        cyc();
        b_ack = 1'b0;
        b_eat = 1'b0;
        n = 1;
        while (b_tick !== 1'b1 && n < 300) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        int highs;
        int per[6];
        per = '{16, 12, 8, 8, 8, 8};

        rst_n = 1'b0;
        {a_phase, a_start, a_pause, a_ready, a_ack, a_fail, a_succ, a_eat} = '0;
        {b_phase, b_start, b_pause, b_ready, b_ack, b_fail, b_succ, b_eat} = '0;
        #12;
        want("rst_state", 0);   chk(a_state);
        want("rst_tick", 0);    chk(a_tick);
        want("rst_flags", 0);   chk({a_failure, a_success});
        want("rst_score", 0);   chk(a_score);
        want("rst_level", 0);   chk(a_level);
        rst_n = 1'b1;
        cyc();

        // ---- MODE=0 ----
        a_ready = 1'b1; a_start = 1'b1; want("m0_start_state", 1); cyc(); a_start = 1'b0;
        chk(a_state);
        a_phase = 1'b1; want("m0_tick_rise", 1); cyc(); chk(a_tick);
        a_phase = 1'b0; want("m0_tick_hold_2nd_edge", 1); cyc(); chk(a_tick);
        a_ack = 1'b1; want("m0_ack_clear", 0); cyc(); a_ack = 1'b0; chk(a_tick);
        cyc(); cyc(); want("m0_no_extra_tick", 0); chk(a_tick);
`ifdef GAME_TICK_DROP_CNT_EN
        want("m0_drop1", 1); chk(a_drop);
`endif
        a_phase = 1'b1; want("m0_tick_rise2", 1); cyc(); chk(a_tick);
        a_phase = 1'b0; a_ack = 1'b1; want("m0_ack_wins", 0); cyc(); a_ack = 1'b0;
        chk(a_tick);
        want("m0_ack_wins_no_late", 0); cyc(); chk(a_tick);
        a_ready = 1'b0; a_phase = 1'b1; want("m0_not_ready_drop", 0); cyc();
        a_ready = 1'b1; chk(a_tick);
        cyc(); want("m0_not_ready_lost", 0); chk(a_tick);
`ifdef GAME_TICK_DROP_CNT_EN
        want("m0_drop3", 3); chk(a_drop);
`endif
        a_pause = 1'b1; want("m0_pause_state", 2); cyc(); a_pause = 1'b0; chk(a_state);
        a_phase = 1'b0; want("m0_pause_no_tick", 0); cyc(); chk(a_tick);
        a_pause = 1'b1; want("m0_resume_state", 1); cyc(); a_pause = 1'b0; chk(a_state);
        want("m0_resume_no_spurious", 0); cyc(); chk(a_tick);
        a_phase = 1'b1; want("m0_resume_tick", 1); cyc(); chk(a_tick);
        a_ack = 1'b1; cyc(); a_ack = 1'b0;

        a_fail = 1'b1; a_succ = 1'b1; a_eat = 1'b1; cyc();
        a_fail = 1'b0; a_succ = 1'b0; a_eat = 1'b0;
        want("m0_over_state", 3);  chk(a_state);
        want("m0_over_fail", 1);   chk(a_failure);
        want("m0_over_succ", 0);   chk(a_success);
        want("m0_over_score", 1);  chk(a_score);
        a_start = 1'b1; cyc(); a_start = 1'b0;
        want("m0_restart_state", 0); chk(a_state);
        want("m0_restart_score", 0); chk(a_score);
        want("m0_restart_flags", 0); chk({a_failure, a_success});
        want("m0_restart_level", 0); chk(a_level);
`ifdef GAME_TICK_DROP_CNT_EN
        want("m0_restart_drop", 0); chk(a_drop);
`endif
        a_start = 1'b1; cyc(); a_start = 1'b0;
        a_eat = 1'b1; repeat (5) cyc(); a_eat = 1'b0;
        want("m0_score_sat", 3); chk(a_score);
        want("m0_level_after5", 1); chk(a_level);
        a_phase = 1'b0; want("m0_tick_before_rst", 1); cyc(); chk(a_tick);

        // ---- MODE=1 ----
        b_ready = 1'b1; b_start = 1'b1; want("m1_start_state", 1); cyc(); b_start = 1'b0;
        chk(b_state);
        b_wait(n); want("m1_first_latency", 20); chk(n);
        b_next(1'b0, n); want("m1_interval_lvl0", 20); chk(n);
        for (int i = 0; i < 6; i++) begin
            b_next(1'b1, n); want($sformatf("m1_interval_eat%0d", i + 1), per[i]); chk(n);
        end
        want("m1_level6", 6); chk(b_level);
        want("m1_score6", 6); chk(b_score);
        for (int i = 0; i < 3; i++) begin
            b_next(1'b1, n); want($sformatf("m1_interval_eat%0d", i + 7), 8); chk(n);
        end
        want("m1_level_sat", 7); chk(b_level);
        want("m1_score9", 9); chk(b_score);

        b_ack = 1'b1; b_ready = 1'b0; cyc(); b_ack = 1'b0;
        repeat (12) cyc();
        want("m1_hold_not_ready", 0); chk(b_tick);
        b_ready = 1'b1; want("m1_hold_retry", 1); cyc(); chk(b_tick);
`ifdef GAME_TICK_DROP_CNT_EN
        want("m1_drop_hold", 6); chk(b_drop);
`endif
        b_ack = 1'b1; cyc(); b_ack = 1'b0;
        b_pause = 1'b1; want("m1_pause_state", 2); cyc(); b_pause = 1'b0; chk(b_state);
        highs = 0;
        repeat (100) begin
            cyc();
            if (b_tick === 1'b1) highs++;
        end
        want("m1_pause_no_tick", 0); chk(highs);
        b_pause = 1'b1; want("m1_resume_state", 1); cyc(); b_pause = 1'b0; chk(b_state);
        b_wait(n); want("m1_resume_remaining", 6); chk(n);

        // ---- asynchronous reset mid-cycle ----
        cyc();
        #2 rst_n = 1'b0;
        #1;
        want("arst_a_tick", 0);  chk(a_tick);
        want("arst_a_state", 0); chk(a_state);
        want("arst_a_score", 0); chk(a_score);
        want("arst_a_level", 0); chk(a_level);
        want("arst_a_flags", 0); chk({a_failure, a_success});
        want("arst_b_tick", 0);  chk(b_tick);
        want("arst_b_state", 0); chk(b_state);
        want("arst_b_score", 0); chk(b_score);
        want("arst_b_level", 0); chk(b_level);
`ifdef GAME_TICK_DROP_CNT_EN
        want("arst_drop", 0); chk({a_drop, b_drop});
`endif
        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_tick_ctrl.md
Name: game_tick_ctrl

Overview:
- Parametrised successor to the game-top tick/phase logic.
- Owns the game-flow FSM (idle/run/pause/over), tick generation, sticky end flags, score and speed level.
- Tick source is selectable: external phase toggles, or an internal divider whose period shrinks as the level rises.
- Sits between the input/phase pins and the snake/apple/vga instances. Its `o_tick` drives the snake tick; its `i_tick_ack` comes from the snake first-segment strobe.

Parameters:
- MODE, 0, tick source: 0 = external `i_phase` toggle, 1 = internal divider.
- BASE_PERIOD, 1000000, divider period in clk cycles at level 0 (MODE=1 only).
- STEP, 50000, period reduction per level.
- MIN_PERIOD, 200000, lower clamp on period.
- LEVELS, 8, number of speed levels; level saturates at LEVELS-1.
- APPLES_PER_LEVEL, 4, eats needed to advance one level.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_phase  in  1  external tick phase; each toggle requests one tick (MODE=0)
- i_start  in  1  single-cycle pulse: start game / restart after game over
- i_pause  in  1  single-cycle pulse: toggle pause
- i_ready  in  1  apple logic ready for a tick
- i_tick_ack  in  1  snake consumed the tick (first-segment strobe)
- i_failure  in  1  snake failure pulse
- i_success  in  1  snake success pulse
- i_eat  in  1  apple eaten pulse
- o_tick  out  1  pending game tick
- o_state  out  3  FSM state code
- o_failure  out  1  sticky failure
- o_success  out  1  sticky success
- o_score  out  SCORE_W  apples eaten, saturating
- o_level  out  $clog2(LEVELS)  current speed level

Behaviour:
- Reset is asynchronous active-low. All outputs are 0, state is IDLE, divider is 0, phase register is 0.
- State codes: IDLE=0, RUN=1, PAUSE=2, OVER_FAIL=3, OVER_WIN=4.
- FSM transitions:
  - IDLE -> RUN on `i_start`.
  - RUN <-> PAUSE on `i_pause`.
  - RUN/PAUSE -> OVER_FAIL on `i_failure`.
  - RUN/PAUSE -> OVER_WIN on `i_success`.
  - `i_failure` and `i_success` in the same cycle: failure wins (OVER_FAIL, only `o_failure` set).
  - OVER_* -> IDLE on `i_start`; this clears score, level, sticky flags and `o_tick`.
- Phase register:
  - Copies `i_phase` every cycle while not in RUN, so entering RUN never produces a spurious edge.
  - In RUN, a toggle (`i_phase != phase_q`) is a tick request. `phase_q` updates in the same cycle.
- Divider (MODE=1):
  - Counts only in RUN and freezes in PAUSE. Resets to 0 on entering RUN from IDLE.
  - period = max(MIN_PERIOD, BASE_PERIOD - level*STEP), computed at full width with no underflow.
  - Request fires when count == period-1; the count then wraps to 0.
  - If a request cannot be accepted (`i_ready` low or `o_tick` high), the count holds at period-1 and the request is retried each cycle. Nothing is dropped.
- Tick acceptance:
  - A request is accepted when state==RUN, `i_ready`=1 and `o_tick`=0. `o_tick` is 1 from the next cycle.
  - `o_tick` clears the cycle after `i_tick_ack`.
  - Ack and a request in the same cycle: the ack wins, `o_tick` goes to 0, and the request is not accepted.
  - MODE=0 requests that are not accepted are dropped; that phase edge is lost.
- Scoring and level:
  - `i_eat` in any state except IDLE increments the score, saturating at all ones. This includes a cycle that also carries failure.
  - An internal eat counter wraps at APPLES_PER_LEVEL and increments the level, saturating at LEVELS-1.
- Latency: all outputs are registered, one cycle after the causing input.

Optional Feature:
- Macro: GAME_TICK_DROP_CNT_EN.
- Enabled:
  - Adds output `o_dropped` [7:0], a saturating count of tick requests not accepted while in RUN. This covers MODE=0 dropped edges, and MODE=1 cycles spent holding at period-1.
  - Cleared at reset and on OVER_* -> IDLE.
- Disabled: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- MODE=0, reset, `i_start`, toggle `i_phase` with `i_ready`=1 -> `o_tick`=1 one cycle later; `i_tick_ack` -> `o_tick`=0 next cycle; `o_state`=1.
- MODE=0, second toggle before ack -> `o_tick` stays 1, with no extra tick after the ack; the drop counter shows 1 when GAME_TICK_DROP_CNT_EN is enabled.
- MODE=1, BASE_PERIOD=20, STEP=4, MIN_PERIOD=8, APPLES_PER_LEVEL=1 -> tick intervals 20, 16, 12, 8, 8 cycles after 0, 1, 2, 3, 4 eats.
- RUN, `i_pause` -> divider frozen and no ticks for 100 cycles; second `i_pause` -> resumes at the frozen count.
- `i_failure` + `i_success` + `i_eat` in the same cycle -> `o_state`=3, `o_failure`=1, `o_success`=0, score+1; `i_start` -> `o_state`=0, score=0, flags=0.
- SCORE_W=2: 5 eats -> `o_score`=3 (saturated). Assert rst_n mid-RUN with `o_tick`=1 -> all outputs 0 immediately, without waiting for a clk edge.
